// File: rtl/iobuf_pkg.sv
// rtl/iobuf_pkg.sv - shared types and constants for the single-wire pad responder
// Contents: FSM state enum, line-level bit constants, default timing parameters
// and a helper that sizes the bit/turn timer.
package iobuf_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      TURN,
      TX_START,
      TX_DATA,
      TX_STOP
   } peer_state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   localparam int DEF_BIT_CYCLES  = 4;
   localparam int DEF_TURN_CYCLES = 2;

   // Width needed to hold the largest reload value (period - 1) of either timer use.
   function automatic int timer_width(input int bit_cycles, input int turn_cycles);
      int longest;
      longest = (bit_cycles > turn_cycles) ? bit_cycles : turn_cycles;
      return (longest > 2) ? $clog2(longest) : 1;
   endfunction

endpackage

// File: rtl/iobuf_bit_timer.sv
// rtl/iobuf_bit_timer.sv - loadable down-counter pacing half bits, full bits and turnaround
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   load       load load_val this cycle (takes priority over counting)
//   load_val   reload value; expire rises load_val+1 cycles after the load edge
//   expire     high while the count sits at zero
module iobuf_bit_timer #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expire = (cnt == '0);

endmodule

// File: rtl/iobuf_peer.sv
// rtl/iobuf_peer.sv - far-end responder: receives a request frame, answers with a response frame
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   dinout      shared single-wire line, driven only while z=0, pulled up externally
//   z           1 = line released, 0 = driving
//   rx_data     last received request payload
//   rx_valid    one-cycle pulse, rx_data is new
//   rx_err      one-cycle pulse, request stop bit sampled low
//   resp_data   response payload, captured at the end of the turnaround
//   busy        high in every state except IDLE
//   tx_done     one-cycle pulse in the cycle the line is released after a response
module iobuf_peer
   import iobuf_pkg::*;
#(
   parameter int BIT_CYCLES  = DEF_BIT_CYCLES,
   parameter int TURN_CYCLES = DEF_TURN_CYCLES,
   parameter int DATA_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   inout  wire               dinout,
   output logic              z,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              rx_err,
   input  logic [DATA_W-1:0] resp_data,
   output logic              busy,
   output logic              tx_done
);

   localparam int CNT_W = timer_width(BIT_CYCLES, TURN_CYCLES);
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [CNT_W-1:0] LD_HALF = CNT_W'(BIT_CYCLES / 2 - 1);
   localparam logic [CNT_W-1:0] LD_FULL = CNT_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_TURN = CNT_W'(TURN_CYCLES - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   peer_state_t state, state_nxt;

   logic              line_q;
   logic [DATA_W-1:0] shreg;
   logic [BIT_W-1:0]  bit_cnt;
   logic              err_wait;

   logic              tmr_load;
   logic [CNT_W-1:0]  tmr_val;
   logic              expire;

   logic              shift_rx;
   logic              shift_tx;
   logic              cap_resp;
   logic              bit_clr;
   logic              bit_inc;
   logic              rx_valid_nxt;
   logic              rx_err_nxt;
   logic              tx_done_nxt;
   logic              err_wait_nxt;
   logic              drive_bit;

   iobuf_bit_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expire   (expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      tmr_load     = 1'b0;
      tmr_val      = LD_FULL;
      shift_rx     = 1'b0;
      shift_tx     = 1'b0;
      cap_resp     = 1'b0;
      bit_clr      = 1'b0;
      bit_inc      = 1'b0;
      rx_valid_nxt = 1'b0;
      rx_err_nxt   = 1'b0;
      tx_done_nxt  = 1'b0;
      err_wait_nxt = err_wait;
      z            = 1'b1;
      drive_bit    = STOP_BIT;
      busy         = (state != IDLE);

      case (state)
         IDLE: begin
            // Half-bit delay so every later sample lands mid-bit.
            if (line_q == START_BIT) begin
               state_nxt = RX_START;
               tmr_load  = 1'b1;
               tmr_val   = LD_HALF;
            end
         end

         RX_START: begin
            if (expire) begin
               if (line_q == START_BIT) begin
                  state_nxt = RX_DATA;
                  tmr_load  = 1'b1;
                  bit_clr   = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end

         RX_DATA: begin
            if (expire) begin
               shift_rx = 1'b1;
               tmr_load = 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  state_nxt = RX_STOP;
               end else begin
                  bit_inc = 1'b1;
               end
            end
         end

         RX_STOP: begin
            // After a framing error the timer is left idle; err_wait keeps
            // the stop sample from firing again while the line is still low.
            if (err_wait) begin
               if (line_q == STOP_BIT) begin
                  state_nxt    = IDLE;
                  err_wait_nxt = 1'b0;
               end
            end else if (expire) begin
               if (line_q == STOP_BIT) begin
                  rx_valid_nxt = 1'b1;
                  state_nxt    = TURN;
                  tmr_load     = 1'b1;
                  tmr_val      = LD_TURN;
               end else begin
                  rx_err_nxt   = 1'b1;
                  err_wait_nxt = 1'b1;
               end
            end
         end

         TURN: begin
            if (expire) begin
               cap_resp  = 1'b1;
               state_nxt = TX_START;
               tmr_load  = 1'b1;
            end
         end

         TX_START: begin
            z         = 1'b0;
            drive_bit = START_BIT;
            if (expire) begin
               state_nxt = TX_DATA;
               tmr_load  = 1'b1;
               bit_clr   = 1'b1;
            end
         end

         TX_DATA: begin
            z         = 1'b0;
            drive_bit = shreg[0];
            if (expire) begin
               shift_tx = 1'b1;
               tmr_load = 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  state_nxt = TX_STOP;
               end else begin
                  bit_inc = 1'b1;
               end
            end
         end

         TX_STOP: begin
            z         = 1'b0;
            drive_bit = STOP_BIT;
            if (expire) begin
               state_nxt   = IDLE;
               tx_done_nxt = 1'b1;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // Idle-high reset value keeps the first cycle out of reset from
         // looking like a start bit.
         line_q   <= STOP_BIT;
         shreg    <= '0;
         bit_cnt  <= '0;
         err_wait <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         line_q   <= dinout;
         err_wait <= err_wait_nxt;
         rx_valid <= rx_valid_nxt;
         rx_err   <= rx_err_nxt;
         tx_done  <= tx_done_nxt;

         if (bit_clr) begin
            bit_cnt <= '0;
         end else if (bit_inc) begin
            bit_cnt <= bit_cnt + 1'b1;
         end

         // One shift register serves both directions: LSB-first in, LSB-first out.
         if (cap_resp) begin
            shreg <= resp_data;
         end else if (shift_rx) begin
            shreg <= {line_q, shreg[DATA_W-1:1]};
         end else if (shift_tx) begin
            shreg <= shreg >> 1;
         end

         if (rx_valid_nxt) begin
            rx_data <= shreg;
         end
      end
   end

   assign dinout = z ? 1'bz : drive_bit;

endmodule
